// File: rtl/vic_video_pattern.sv
// vic_video_pattern
// Video timing generator with a registered four-mode test-pattern engine.
//
// Ports:
//   clk            pixel clock
//   reset          asynchronous, active-high reset
//   i_mode         requested pattern (0 ramp, 1 bars, 2 checkerboard, 3 scroll),
//                  sampled only on the last pixel of a frame
//   o_hsync/o_vsync       sync outputs, active level HSYNC_POL / VSYNC_POL
//   o_display_on          high while the output pixel is in the active area
//   o_hpos/o_vpos         position of the output pixel
//   o_red/o_green/o_blue  colour channels, 0 outside the active area
//   o_frame_start         one-clock pulse on pixel (0,0)
//
// All outputs are registered and lag the raster counters by one clock.
//
// Build option: define VIC_PATGEN_BORDER_EN to force a full-white one-pixel
// frame around the active area in every mode.
module vic_video_pattern #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   POS_W     = 10,
    parameter int   COLOR_W   = 4,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         i_mode,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_display_on,
    output logic [POS_W-1:0]   o_hpos,
    output logic [POS_W-1:0]   o_vpos,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_green,
    output logic [COLOR_W-1:0] o_blue,
    output logic               o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX     = (1 << COLOR_W) - 1;

    localparam logic [POS_W-1:0]   H_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]   V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]   H_ACT      = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0]   V_ACT      = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0]   H_ACT_LAST = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0]   V_ACT_LAST = POS_W'(V_ACTIVE - 1);
    localparam logic [POS_W-1:0]   HS_FIRST   = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0]   HS_LAST    = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [POS_W-1:0]   VS_FIRST   = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0]   VS_LAST    = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [POS_W-1:0]   BAR_RELOAD = POS_W'(H_ACTIVE / 8 - 1);
    localparam logic [COLOR_W-1:0] C_MAX      = COLOR_W'(MAX);
    localparam logic [COLOR_W-1:0] RAMP_LAST  = COLOR_W'(MAX - 1);

    // raster state
    logic [POS_W-1:0]   hcnt_q, hcnt_d;
    logic [POS_W-1:0]   vcnt_q, vcnt_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [1:0]         mode_q, mode_d;
    // bar counter: down-counter over one bar width, plus bar index
    logic [POS_W-1:0]   bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    // vcnt mod MAX, tracked incrementally instead of with a divider
    logic [COLOR_W-1:0] ramp_q, ramp_d;

    // output stage
    logic               hsync_q, vsync_q, de_q, fs_q;
    logic [POS_W-1:0]   hpos_q, vpos_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;

    logic               h_last, v_last, frame_end, active, hs_act, vs_act;
    logic [COLOR_W-1:0] red_d, green_d, blue_d;
    logic [4:0]         scroll_sum;

    always_comb begin
        h_last    = (hcnt_q == H_LAST);
        v_last    = (vcnt_q == V_LAST);
        frame_end = h_last && v_last;
        active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_act    = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
        vs_act    = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);

        hcnt_d      = h_last ? '0 : hcnt_q + 1'b1;
        vcnt_d      = vcnt_q;
        ramp_d      = ramp_q;
        if (h_last) begin
            vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            ramp_d = (v_last || ramp_q == RAMP_LAST) ? '0 : ramp_q + 1'b1;
        end

        frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
        mode_d      = frame_end ? i_mode : mode_q;

        // Bar state always describes the current hcnt; it rearms for the next line
        // on the wrap cycle so hcnt=0 starts in bar 0.
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (h_last) begin
            bar_cnt_d = BAR_RELOAD;
            bar_idx_d = '0;
        end else if (hcnt_q < H_ACT) begin
            if (bar_cnt_q == '0) begin
                bar_cnt_d = BAR_RELOAD;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        red_d      = '0;
        green_d    = '0;
        blue_d     = '0;
        scroll_sum = hcnt_q[4:0] + frame_cnt_q[4:0];
        if (active) begin
            case (mode_q)
                2'd0: begin
                    red_d   = ramp_q;
                    green_d = ramp_q;
                    blue_d  = ramp_q;
                end
                2'd1: begin
                    red_d   = bar_idx_q[2] ? C_MAX : '0;
                    green_d = bar_idx_q[1] ? C_MAX : '0;
                    blue_d  = bar_idx_q[0] ? C_MAX : '0;
                end
                2'd2: begin
                    if (hcnt_q[3] ^ vcnt_q[3]) begin
                        red_d   = C_MAX;
                        green_d = C_MAX;
                        blue_d  = C_MAX;
                    end
                end
                default: begin
                    // (hcnt + frame_cnt) & 31 < 8  <=>  top two bits of the 5-bit sum clear
                    blue_d = C_MAX;
                    if (scroll_sum[4:3] == 2'b00) begin
                        red_d   = C_MAX;
                        green_d = C_MAX;
                    end
                end
            endcase
`ifdef VIC_PATGEN_BORDER_EN
            if (hcnt_q == '0 || hcnt_q == H_ACT_LAST ||
                vcnt_q == '0 || vcnt_q == V_ACT_LAST) begin
                red_d   = C_MAX;
                green_d = C_MAX;
                blue_d  = C_MAX;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            bar_cnt_q   <= BAR_RELOAD;
            bar_idx_q   <= '0;
            ramp_q      <= '0;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            hpos_q      <= '0;
            vpos_q      <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            ramp_q      <= ramp_d;
            hsync_q     <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync_q     <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            de_q        <= active;
            fs_q        <= (hcnt_q == '0) && (vcnt_q == '0);
            hpos_q      <= hcnt_q;
            vpos_q      <= vcnt_q;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_display_on  = de_q;
    assign o_frame_start = fs_q;
    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_red         = red_q;
    assign o_green       = green_q;
    assign o_blue        = blue_q;

endmodule

// File: tb/tb_vic_video_pattern.sv
// Testbench for vic_video_pattern on a reduced raster (80x27 clocks per frame)
// so many frames fit in a short run. Outputs are compared every clock against
// a model that derives each pixel from the elapsed clock count since reset.
module tb_vic_video_pattern;

    localparam int   HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int   VA = 20, VFP = 2, VS = 2, VBP = 3;
    localparam int   PW = 8, CW = 4;
    localparam logic HP = 1'b0, VP = 1'b1;
    localparam int   HT = HA + HFP + HS + HBP;
    localparam int   VT = VA + VFP + VS + VBP;
    localparam int   FRAME = HT * VT;
    localparam int   MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    i_mode = 2'd0;
    logic          o_hsync, o_vsync, o_display_on, o_frame_start;
    logic [PW-1:0] o_hpos, o_vpos;
    logic [CW-1:0] o_red, o_green, o_blue;

    int n_chk = 0;
    int n_bad = 0;
    int k = 0;
    int m_mode = 0;
    int pend = 0;

    always #5 clk = ~clk;

    vic_video_pattern #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .POS_W(PW), .COLOR_W(CW), .HSYNC_POL(HP), .VSYNC_POL(VP)
    ) dut (
        .clk(clk), .reset(reset), .i_mode(i_mode),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_display_on(o_display_on),
        .o_hpos(o_hpos), .o_vpos(o_vpos),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_frame_start(o_frame_start)
    );

    function automatic logic [31:0] dut_vec();
        return {o_hsync, o_vsync, o_display_on, o_frame_start,
                o_hpos, o_vpos, o_red, o_green, o_blue};
    endfunction

    function automatic logic [31:0] reset_vec();
        return {~HP, ~VP, 2'b00, 28'd0};
    endfunction

    // Expected outputs for the t-th pixel since reset release, shown in mode md.
    function automatic logic [31:0] model(input int t, input int md);
        int f, p, h, v, idx;
        logic act, hs, vs, white;
        logic [CW-1:0] r, g, b;
        f = t / FRAME;
        p = t % FRAME;
        h = p % HT;
        v = p / HT;
        act = (h < HA) && (v < VA);
        hs = (h >= HA + HFP && h < HA + HFP + HS) ? HP : ~HP;
        vs = (v >= VA + VFP && v < VA + VFP + VS) ? VP : ~VP;
        r = '0; g = '0; b = '0;
        white = 1'b0;
        if (act) begin
            case (md)
                0: begin
                    r = CW'(v % MAXV); g = r; b = r;
                end
                1: begin
                    idx = h / (HA / 8);
                    r = ((idx & 4) != 0) ? CW'(MAXV) : '0;
                    g = ((idx & 2) != 0) ? CW'(MAXV) : '0;
                    b = ((idx & 1) != 0) ? CW'(MAXV) : '0;
                end
                2: white = ((((h / 8) ^ (v / 8)) & 1) == 1);
                default: begin
                    b = CW'(MAXV);
                    white = (((h + (f % 256)) & 31) < 8);
                end
            endcase
`ifdef VIC_PATGEN_BORDER_EN
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) white = 1'b1;
`endif
            if (white) begin
                r = CW'(MAXV); g = CW'(MAXV); b = CW'(MAXV);
            end
        end
        return {hs, vs, act, (p == 0), PW'(h), PW'(v), r, g, b};
    endfunction

    // Per-cycle compare against the model.
    initial begin
        logic [31:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                k = 0; m_mode = 0; pend = 0;
                n_chk++;
                if (dut_vec() !== reset_vec()) begin
                    n_bad++;
                    $display("FAIL in_reset got=%h exp=%h", dut_vec(), reset_vec());
                end
            end else begin
                k++;
                if (k > 1 && ((k - 1) % FRAME) == 0) m_mode = pend;
                exp_v = model(k - 1, m_mode);
                n_chk++;
                if (dut_vec() !== exp_v) begin
                    n_bad++;
                    $display("FAIL pixel t=%0d mode=%0d got=%h exp=%h", k - 1, m_mode, dut_vec(), exp_v);
                end
                if ((k % FRAME) == 0) pend = int'(i_mode);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp_v);
        end
    endtask

    function automatic int rgb();
        return int'({o_red, o_green, o_blue});
    endfunction

    task automatic wait_pos(input int v, input int h);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(int'(o_vpos) == v && int'(o_hpos) == h) && n < 3 * FRAME);
        if (n >= 3 * FRAME) begin
            n_chk++;
            n_bad++;
            $display("FAIL wait_pos v=%0d h=%0d got=timeout exp=reached", v, h);
        end
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        i_mode = 2'(m);
    endtask

    initial begin
        int n, rst_at;
        repeat (3) @(negedge clk);
        chk("rst_hsync", int'(o_hsync), 1);
        chk("rst_vsync", int'(o_vsync), 0);
        chk("rst_rgb", rgb(), 0);
        chk("rst_de", int'(o_display_on), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_fs", int'(o_frame_start), 1);
        chk("first_pos", int'({o_vpos, o_hpos}), 0);

        // frame 0, ramp
        wait_pos(14, 3);  chk("ramp_v14", rgb(), 'hEEE);
        wait_pos(15, 3);  chk("ramp_v15", rgb(), 'h000);
        wait_pos(16, 64); chk("ramp_h64_rgb", rgb(), 0);
        chk("ramp_h64_de", int'(o_display_on), 0);
        wait_pos(16, 67); chk("hs_before", int'(o_hsync), 1);
        wait_pos(16, 68); chk("hs_first_low", int'(o_hsync), 0);
        set_mode(1);
        wait_pos(17, 5);  chk("ramp_held", rgb(), 'h222);

        // frame 1, bars
        wait_pos(2, 7);   chk("bar_h7", rgb(), 'h000);
        wait_pos(2, 8);   chk("bar_h8", rgb(), 'h00F);
        wait_pos(2, 63);  chk("bar_h63", rgb(), 'hFFF);
        set_mode(3);

        // frames 2 and 3, scroll with frame_cnt 2 then 3
        wait_pos(1, 5);   chk("scr_f2_h5", rgb(), 'hFFF);
        wait_pos(1, 6);   chk("scr_f2_h6", rgb(), 'h00F);
        wait_pos(1, 4);   chk("scr_f3_h4", rgb(), 'hFFF);
        wait_pos(1, 5);   chk("scr_f3_h5", rgb(), 'h00F);
        set_mode(2);

        // frame 4, checkerboard
        wait_pos(1, 0);
`ifdef VIC_PATGEN_BORDER_EN
        chk("chk_border", rgb(), 'hFFF);
`else
        chk("chk_h0", rgb(), 'h000);
`endif
        wait_pos(1, 8);   chk("chk_h8v1", rgb(), 'hFFF);
        wait_pos(8, 8);   chk("chk_h8v8", rgb(), 'h000);
        wait_pos(21, 79); chk("vs_before", int'(o_vsync), 0);
        wait_pos(22, 0);  chk("vs_first", int'(o_vsync), 1);

        // reset mid-frame must act without a clock
        wait_pos(10, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst", int'(dut_vec()), int'(reset_vec()));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rerun_fs", int'(o_frame_start), 1);
        chk("rerun_pos", int'({o_vpos, o_hpos}), 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_frame_start && n < 2 * FRAME);
        chk("fs_period", n, FRAME);

        // randomized mode requests with one random reset pulse
        rst_at = int'($urandom_range(1000, 6 * FRAME));
        for (int c = 0; c < 8 * FRAME; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) i_mode = 2'($urandom_range(0, 3));
            if (c == rst_at) reset = 1'b1;
            if (c == rst_at + 2) reset = 1'b0;
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
